serial_ripple_borrow_subtractor: RTL
====================================

# serial_ripple_borrow_subtractor

Bit-serial ripple-borrow subtractor: computes A − B − Bin one bit per clock, LSB first, with the borrow held in a flip-flop between bits. It is the inverse-direction companion of the team's ripple-carry adder and uses the same full-subtractor cell in time rather than in space. It sits beside the adder in the arithmetic datapath. A start/busy/done handshake frames each operation, and a registered result is held until the next operation completes.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous and active-high
- start  input  1  request an operation; sampled only when idle or in the done cycle
- A  input  WIDTH  minuend, captured on the accepting edge
- B  input  WIDTH  subtrahend, captured on the accepting edge
- Bin  input  1  borrow-in, captured on the accepting edge
- D  output  WIDTH  difference, registered, updated only on completion
- Bout  output  1  borrow-out, registered, updated only on completion
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, high when D and Bout hold a new result

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: processing bits.
  - DONE: one cycle, result just written.
- IDLE or DONE with start=1 → SHIFT.
  - Latch A and B into internal shift registers and Bin into the borrow flop.
  - Clear the bit counter to 0.
- DONE with start=0 → IDLE.
- SHIFT, each edge, on the current LSBs a and b and the borrow br:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - Shift both operand registers right by one.
  - Shift d into the MSB of the internal difference register.
  - Increment the counter.
- SHIFT, on the edge that processes bit WIDTH−1:
  - Write D from the final difference register and Bout from br_next.
  - Go to DONE.
- Arithmetic: D = (A − B − Bin) mod 2^WIDTH. Bout = 1 iff A < B + Bin, unsigned.
- start is ignored while busy=1.
- A, B and Bin are ignored except on the accepting edge. Changing them mid-operation has no effect.
- D and Bout keep the previous result through the whole next operation and change only on the completing edge.

## Timing
- Reset (rst=1 at any edge, in any state):
  - state=IDLE, D=0, Bout=0, busy=0, done=0.
  - Internal registers and counter are cleared.
- Reset during SHIFT aborts the operation. No done pulse is produced and D/Bout read 0.
- rst has priority over start in the same cycle.
- Latency, with start accepted at edge k:
  - busy=1 after edges k … k+WIDTH−1.
  - Bits 0 … WIDTH−1 are processed at edges k+1 … k+WIDTH.
  - After edge k+WIDTH: D and Bout are valid, done=1 and busy=0.
  - After edge k+WIDTH+1: done=0, unless a new start was accepted.
- Back-to-back operation: start=1 during the done cycle is accepted at edge k+WIDTH+1.
  - busy rises after that edge and done falls.
  - Throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.
- done never stays high for two consecutive cycles.

## Test plan
- Reset: apply rst for 2 cycles → D=0000, Bout=0, busy=0, done=0. Assert start and rst together → remain IDLE.
- Basic cases, WIDTH=4:
  - A=0101, B=0011, Bin=0 → D=0010, Bout=0.
  - busy is high for exactly 4 cycles and done pulses once, after edge k+4.
- Borrow cases:
  - A=0011, B=0101, Bin=0 → D=1110, Bout=1.
  - A=0000, B=0000, Bin=1 → D=1111, Bout=1.
  - A=1000, B=0001, Bin=1 → D=0110, Bout=0.
  - A=1111, B=1111, Bin=0 → D=0000, Bout=0.
- Protocol robustness:
  - Pulse start again and change A/B on the second busy cycle → first result is unaffected and the second start is ignored.
  - D holds the prior result until completion.
- Abort: assert rst on the 2nd busy cycle → D=0, Bout=0, no done. A new start then yields the correct result.
- Exhaustive with back-to-back operation: all 512 combinations of A, B and Bin, issuing each start in the done cycle.
  - Every result matches the reference model A − B − Bin.
  - Spacing between done pulses is exactly 5 cycles.

Source files
------------

// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B - Bin, one bit per clock, LSB first.
// A start/busy/done handshake frames each operation; D/Bout hold until the next completion.
module serial_ripple_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic [WIDTH-1:0] o_d,
    output logic             o_bout,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Full-subtractor cell, returned as {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
        full_sub = {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic [1:0]       w_fs;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_diff_next;

    assign w_fs        = full_sub(r_a[0], r_b[0], r_br);
    assign w_d         = w_fs[0];
    assign w_br_next   = w_fs[1];
    assign w_diff_next = {w_d, r_diff[WIDTH-1:1]};

    // Handshake FSM and bit-serial datapath.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_diff  <= {WIDTH{1'b0}};
            r_br    <= 1'b0;
            r_cnt   <= CNT_ZERO;
            o_d     <= {WIDTH{1'b0}};
            o_bout  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_br    <= i_bin;
                        r_cnt   <= CNT_ZERO;
                        o_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a    <= {1'b0, r_a[WIDTH-1:1]};
                    r_b    <= {1'b0, r_b[WIDTH-1:1]};
                    r_br   <= w_br_next;
                    r_diff <= w_diff_next;
                    r_cnt  <= r_cnt + CNT_ONE;
                    // The edge that consumes the MSB publishes the result.
                    if (r_cnt == CNT_LAST) begin
                        o_d     <= w_diff_next;
                        o_bout  <= w_br_next;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        o_busy  <= 1'b1;
                        o_done  <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
